// File: rtl/am_ctrl_pkg.sv
// Shared types and opcode constants for the ALU sequencing controller.
package am_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_PRIO   = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_ASR    = 4'd4;
  localparam logic [3:0] OP_ASL    = 4'd5;
  localparam logic [3:0] OP_LSR    = 4'd6;
  localparam logic [3:0] OP_LSL    = 4'd7;
  localparam logic [3:0] OP_DEC2   = 4'd8;
  localparam logic [3:0] OP_DEC4   = 4'd9;
  localparam logic [3:0] OP_MAX    = 4'd10;
  localparam logic [3:0] OP_MIN    = 4'd11;
  localparam logic [3:0] OP_ADD    = 4'd12;
  localparam logic [3:0] OP_SUB    = 4'd13;
  localparam logic [3:0] OP_ABSSUB = 4'd14;
  localparam logic [3:0] OP_MULG   = 4'd15;

endpackage

// File: rtl/am_ctrl_arb.sv
// Two-input round-robin arbiter: a lone requester wins, a contest goes
// to whichever requester was not granted last.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | last_grant);
  assign grant1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/am_ctrl.sv
// Shares one external ALU between two requesters: accept, execute for one
// cycle, then hold the captured result until the owner takes it.
module am_ctrl
  import am_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req1_b,
  input  logic [3:0]       req0_sel,
  input  logic [3:0]       req1_sel,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [15:0]      rsp0_out,
  output logic [15:0]      rsp1_out,
  output logic             rsp0_ovf,
  output logic             rsp1_ovf,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [15:0]      alu_out,
  input  logic             alu_ovf,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  state_t state, state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant0, grant1;
  logic   accept, rsp_done;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Readies are gated by rst_n so they read 0 while reset is held.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 & rst_n;
        req1_ready = grant1 & rst_n;
        accept     = grant0 | grant1;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp0_out   <= '0;
      rsp1_out   <= '0;
      rsp0_ovf   <= 1'b0;
      rsp1_ovf   <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= grant1;
        alu_a   <= grant1 ? req1_a   : req0_a;
        alu_b   <= grant1 ? req1_b   : req0_b;
        alu_sel <= grant1 ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        if (owner) begin
          rsp1_out <= alu_out;
          rsp1_ovf <= alu_ovf;
        end else begin
          rsp0_out <= alu_out;
          rsp0_ovf <= alu_ovf;
        end
      end
      if (rsp_done) begin
        last_grant <= owner;
        if (!owner && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
        if (owner && cnt1 != '1)  cnt1 <= cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_am_ctrl.sv
// Bench for am_ctrl: a behavioural ALU stub, a served-order/count model and
// directed plus randomized scenarios; a CNT_W=2 twin checks saturation.
module tb_am_ctrl;
  import am_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [3:0]  req0_a, req1_a, req0_b, req1_b, req0_sel, req1_sel;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_out, rsp1_out, alu_out;
  logic        rsp0_ovf, rsp1_ovf, alu_ovf, busy;
  logic [3:0]  alu_a, alu_b, alu_sel;
  logic [7:0]  cnt0, cnt1;

  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
  logic [15:0] s_rsp0_out, s_rsp1_out;
  logic        s_rsp0_ovf, s_rsp1_ovf, s_busy;
  logic [3:0]  s_alu_a, s_alu_b, s_alu_sel;
  logic [1:0]  s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;
  logic last_m;       // requester served most recently
  int   cnt_m [2];    // unbounded completion counts

  // Behavioural model of the external 16-function unit: {ovf, out}.
  function automatic logic [16:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    logic signed [3:0] sa, sb;
    logic [3:0]  t;
    logic [7:0]  p;
    logic [15:0] r;
    logic        o;
    sa = a; sb = b; r = '0; o = 1'b0; t = '0;
    case (sel)
      OP_PRIO:   for (int i = 0; i < 4; i++) if (a[i]) r = 16'(i + 1);
      OP_AND:    r = {12'h0, a & b};
      OP_XOR:    r = {12'h0, a ^ b};
      OP_MUL:    begin p = {{4{a[3]}}, a} * {{4{b[3]}}, b}; r = {8'h0, p}; end
      OP_ASR:    begin t = sa >>> b[1:0]; r = {12'h0, t}; end
      OP_ASL:    begin t = a << b[1:0]; r = {12'h0, t}; end
      OP_LSR:    begin t = a >> b[1:0]; r = {12'h0, t}; end
      OP_LSL:    begin t = a << b[1:0]; r = {12'h0, t}; o = a[3]; end
      OP_DEC2:   r = 16'h1 << a[1:0];
      OP_DEC4:   r = 16'h1 << a;
      OP_MAX:    r = {12'h0, (sa > sb) ? a : b};
      OP_MIN:    r = {12'h0, (sa < sb) ? a : b};
      OP_ADD:    begin t = a + b; r = {12'h0, t}; o = (a[3] == b[3]) && (t[3] != a[3]); end
      OP_SUB:    begin t = a - b; r = {12'h0, t}; o = (a[3] != b[3]) && (t[3] != a[3]); end
      OP_ABSSUB: begin t = (sa > sb) ? a - b : b - a; r = {12'h0, t}; end
      default:   begin p = a * b; r = {8'h0, p}; o = |p[7:4]; end
    endcase
    return {o, r};
  endfunction

  always_comb {alu_ovf, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  am_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_out(rsp0_out), .rsp1_out(rsp1_out), .rsp0_ovf(rsp0_ovf), .rsp1_ovf(rsp1_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  am_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(s_req0_ready), .req1_ready(s_req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .rsp0_valid(s_rsp0_valid), .rsp1_valid(s_rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_out(s_rsp0_out), .rsp1_out(s_rsp1_out), .rsp0_ovf(s_rsp0_ovf), .rsp1_ovf(s_rsp1_ovf),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .cnt0(s_cnt0), .cnt1(s_cnt1), .busy(s_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1;
    last_m = 1'b1;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    #1;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic test_reset;
    logic [63:0] all;
    do_reset();
    all = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out, rsp0_ovf, rsp1_ovf,
           alu_a, alu_b, alu_sel, cnt0, cnt1, busy, s_cnt0, s_cnt1};
    checks++; if (all !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all); end
  endtask

  task automatic test_only_req0;
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4; req0_sel = OP_ADD; rsp0_ready = 1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL t1_ready got %b exp 10", {req0_ready, req1_ready}); end
    tick(); req0_valid = 0;
    checks++; if ({busy, rsp0_valid, alu_a, alu_b, alu_sel} !== {2'b10, 4'd3, 4'd4, OP_ADD})
      begin errors++; $display("FAIL t1_exec got %h", {busy, rsp0_valid, alu_a, alu_b, alu_sel}); end
    tick();
    checks++; if ({rsp0_valid, rsp0_ovf, rsp0_out} !== {2'b10, 16'h0007})
      begin errors++; $display("FAIL t1_rsp got %b %b %h exp 1 0 0007", rsp0_valid, rsp0_ovf, rsp0_out); end
    tick(); rsp0_ready = 0; last_m = 0; cnt_m[0]++;
    checks++; if ({busy, rsp0_valid, cnt0} !== {2'b00, 8'd1}) begin errors++; $display("FAIL t1_done busy %b valid %b cnt0 %0d exp 0 0 1", busy, rsp0_valid, cnt0); end
  endtask

  task automatic test_only_req1;
    req1_valid = 1; req1_a = 4'd7; req1_b = 4'd1; req1_sel = OP_ADD; rsp1_ready = 1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL t2_ready got %b exp 01", {req0_ready, req1_ready}); end
    tick(); req1_valid = 0;
    tick();
    checks++; if ({rsp0_valid, rsp1_valid, rsp1_ovf, rsp1_out} !== {3'b011, 16'h0008})
      begin errors++; $display("FAIL t2_rsp got v0 %b v1 %b ovf %b out %h exp 0 1 1 0008", rsp0_valid, rsp1_valid, rsp1_ovf, rsp1_out); end
    tick(); rsp1_ready = 0; last_m = 1; cnt_m[1]++;
    checks++; if ({cnt0, cnt1} !== {8'd1, 8'd1}) begin errors++; $display("FAIL t2_cnt got %0d %0d exp 1 1", cnt0, cnt1); end
  endtask

  task automatic test_back_to_back;
    int e;
    do_reset();
    req0_valid = 1; req0_a = 4'hE; req0_b = 4'd3; req0_sel = OP_MUL;
    req1_valid = 1; req1_a = 4'd5; req1_b = 4'd2; req1_sel = OP_XOR;
    rsp0_ready = 1; rsp1_ready = 1; #1;
    for (int k = 0; k < 6; k++) begin
      e = (k == 0) ? 0 : (last_m ? 0 : 1);
      checks++; if ({req0_ready, req1_ready} !== ((e == 1) ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL t3_grant op %0d got %b exp req%0d", k, {req0_ready, req1_ready}, e); end
      tick(); tick();
      if (e == 0) begin
        checks++; if ({rsp0_valid, rsp1_valid, rsp0_out} !== {2'b10, 16'h00FA}) begin errors++; $display("FAIL t3_rsp0 op %0d got %b%b %h exp 10 00fa", k, rsp0_valid, rsp1_valid, rsp0_out); end
      end else begin
        checks++; if ({rsp0_valid, rsp1_valid, rsp1_out} !== {2'b01, 16'h0007}) begin errors++; $display("FAIL t3_rsp1 op %0d got %b%b %h exp 01 0007", k, rsp0_valid, rsp1_valid, rsp1_out); end
      end
      tick(); last_m = (e == 1); cnt_m[e]++;
    end
    checks++; if ({cnt0, cnt1} !== {8'd3, 8'd3}) begin errors++; $display("FAIL t3_cnt got %0d %0d exp 3 3", cnt0, cnt1); end
    clear_inputs(); #1;
  endtask

  task automatic test_backpressure;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd5; req0_sel = OP_XOR; #1;
    tick(); req0_valid = 0; req1_valid = 1; req1_a = 4'd1; req1_b = 4'd1; req1_sel = OP_AND;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++; if ({rsp0_valid, rsp0_out, req0_ready, req1_ready, busy} !== {1'b1, 16'h0007, 3'b001})
        begin errors++; $display("FAIL t4_hold cyc %0d got v %b out %h rdy %b%b busy %b", k, rsp0_valid, rsp0_out, req0_ready, req1_ready, busy); end
      tick();
    end
    rsp0_ready = 1; tick(); rsp0_ready = 0; last_m = 0; cnt_m[0]++;
    checks++; if ({busy, rsp0_valid, req1_ready, cnt0} !== {3'b001, 8'(sat(cnt_m[0], 255))})
      begin errors++; $display("FAIL t4_release got busy %b v %b r1 %b cnt0 %0d", busy, rsp0_valid, req1_ready, cnt0); end
    clear_inputs(); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] all;
    logic [16:0] er;
    do_reset();
    req0_valid = 1; req0_a = 4'd9; req0_b = 4'd9; req0_sel = OP_ADD; req1_valid = 1;
    req1_a = 4'd9; req1_b = 4'd9; req1_sel = OP_ADD; #1;
    tick(); req0_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_exec busy got %b exp 1", busy); end
    rst_n = 0; #1;
    all = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out, rsp0_ovf, rsp1_ovf,
           alu_a, alu_b, alu_sel, cnt0, cnt1, busy, s_cnt0, s_cnt1};
    checks++; if (all !== '0) begin errors++; $display("FAIL t5_reset_outputs got %h exp 0", all); end
    tick(); tick();
    checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL t5_no_rsp got %b exp 000", {rsp0_valid, rsp1_valid, busy}); end
    rst_n = 1; last_m = 1; cnt_m[0] = 0; cnt_m[1] = 0; rsp1_ready = 1; #1;
    er = alu_f(4'd9, 4'd9, OP_ADD);
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL t5_regrant got %b exp 01", {req0_ready, req1_ready}); end
    tick(); req1_valid = 0; tick();
    checks++; if ({rsp1_valid, rsp1_ovf, rsp1_out} !== {1'b1, er}) begin errors++; $display("FAIL t5_rsp got %b %b %h exp 1 %h", rsp1_valid, rsp1_ovf, rsp1_out, er); end
    tick(); last_m = 1; cnt_m[1]++;
    checks++; if ({cnt0, cnt1} !== {8'd0, 8'd1}) begin errors++; $display("FAIL t5_cnt got %0d %0d exp 0 1", cnt0, cnt1); end
    clear_inputs(); #1;
  endtask

  task automatic test_saturation;
    do_reset();
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = OP_SUB; rsp0_ready = 1; #1;
    for (int k = 1; k <= 5; k++) begin
      tick(); tick(); tick(); cnt_m[0]++; last_m = 0;
      checks++; if ({cnt0, s_cnt0} !== {8'(k), 2'(sat(k, 3))})
        begin errors++; $display("FAIL t6_sat op %0d got cnt0 %0d small %0d exp %0d %0d", k, cnt0, s_cnt0, k, sat(k, 3)); end
    end
    clear_inputs(); #1;
  endtask

  task automatic test_random;
    logic [1:0]  v;
    logic [3:0]  ea, eb, es;
    logic [16:0] er;
    int e, bp;
    for (int k = 0; k < 40; k++) begin
      v = 2'($urandom_range(1, 3));
      req0_valid = v[0]; req1_valid = v[1];
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 4'($urandom);
      #1;
      e = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : (last_m ? 0 : 1);
      ea = e ? req1_a : req0_a; eb = e ? req1_b : req0_b; es = e ? req1_sel : req0_sel;
      er = alu_f(ea, eb, es);
      checks++; if ({req0_ready, req1_ready} !== (e ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL rnd_grant op %0d got %b exp req%0d", k, {req0_ready, req1_ready}, e); end
      tick(); req0_valid = 0; req1_valid = 0;
      checks++; if ({alu_a, alu_b, alu_sel, busy} !== {ea, eb, es, 1'b1})
        begin errors++; $display("FAIL rnd_alu op %0d got %h exp %h", k, {alu_a, alu_b, alu_sel, busy}, {ea, eb, es, 1'b1}); end
      tick();
      bp = $urandom_range(0, 3);
      for (int c = 0; c <= bp; c++) begin
        if (c == bp) begin if (e) rsp1_ready = 1; else rsp0_ready = 1; end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== (e ? 2'b01 : 2'b10) ||
            (e ? {rsp1_ovf, rsp1_out} : {rsp0_ovf, rsp0_out}) !== er)
          begin errors++; $display("FAIL rnd_rsp op %0d got v %b%b data %h exp %h", k, rsp0_valid, rsp1_valid,
                                   e ? {rsp1_ovf, rsp1_out} : {rsp0_ovf, rsp0_out}, er); end
        tick();
      end
      rsp0_ready = 0; rsp1_ready = 0; last_m = (e == 1); cnt_m[e]++;
      checks++; if ({busy, cnt0, cnt1, s_cnt0, s_cnt1} !== {1'b0, 8'(sat(cnt_m[0], 255)), 8'(sat(cnt_m[1], 255)),
                                                       2'(sat(cnt_m[0], 3)), 2'(sat(cnt_m[1], 3))})
        begin errors++; $display("FAIL rnd_cnt op %0d got busy %b cnt %0d %0d small %0d %0d", k, busy, cnt0, cnt1, s_cnt0, s_cnt1); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_only_req0();
    test_only_req1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_ctrl.md
# am_ctrl

Sequencing controller that shares the 4-bit arithmetic/logic unit (16-function, `Sel`-selected, 16-bit `Out` plus `Ovf`) between two requesters. The block handles four things:
- accepts operation requests (A, B, Sel) over valid/ready handshakes;
- arbitrates round-robin between requester 0 and requester 1;
- drives registered operands into the unit and captures its result;
- returns `Out`/`Ovf` to the granted requester over a valid/ready response channel, and keeps a per-requester completed-operation counter.

The unit itself is instantiated beside this block at the level above; `am_ctrl` only drives and samples its ports.

## Interface
Parameters:
- CNT_W, 8, width of each completed-operation counter; counters saturate at all-ones.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle when valid & ready
- req0_a / req1_a  input  4  operand A
- req0_b / req1_b  input  4  operand B
- req0_sel / req1_sel  input  4  function select 0..15
- rsp0_valid / rsp1_valid  output  1  result available
- rsp0_ready / rsp1_ready  input  1  requester takes result
- rsp0_out / rsp1_out  output  16  captured `Out`
- rsp0_ovf / rsp1_ovf  output  1  captured `Ovf`
- alu_a, alu_b, alu_sel  output  4 each  operand/select registers driven to the unit
- alu_out  input  16  unit `Out`, combinational from alu_a/alu_b/alu_sel
- alu_ovf  input  1  unit `Ovf`
- cnt0 / cnt1  output  CNT_W  operations completed per requester
- busy  output  1  high whenever state ≠ IDLE

## Operation
States:
- **IDLE**
  - reqN_ready is high only for the arbiter's grant: combinational from the valids and the last_grant pointer.
  - On an accept, the block latches alu_a, alu_b and alu_sel from the granted requester, records the owner, and moves to EXEC.
- **EXEC**
  - Lasts one cycle, allowing the unit to settle.
  - At the end of the cycle, alu_out/alu_ovf are registered into the response register of the owner, and the state moves to RESP.
- **RESP**
  - rspN_valid is high for the owner only.
  - On rspN_valid & rspN_ready: cntN increments (saturating), last_grant ← owner, and the state returns to IDLE.
  - rspN_valid stays high indefinitely while rspN_ready is low.

Arbitration:
- Only one valid: that requester is granted.
- Both valid: grant goes to the requester not equal to last_grant.
- last_grant resets to 1, so requester 0 wins the first contested grant.

Other rules:
- Requesters must hold valid and payload stable until accepted.
- Payload and valid changes while not ready are ignored. A requester may drop valid without being accepted.
- reqN_ready is 0 in EXEC and RESP. Both readies are never high together.
- The unit's result is passed through unmodified: no re-extension, no re-interpretation of `Ovf`. Results for every Sel value 0..15 are captured identically.

Reset:
- Asserting rst_n low in any state returns to IDLE immediately. The in-flight operation is discarded, with no response and no count.
- Reset values: every output 0 (ready, valid, rsp data, alu_*, cnt, busy); last_grant = 1; owner = 0.

## Timing
- Accept at edge T → alu_* updated after T; EXEC in cycle T+1; rspN_valid high from cycle T+2.
- Minimum latency is 2 cycles from accept to response-valid.
- Minimum period is 3 cycles per operation when rspN_ready is already high.
- Response handshake at edge R → IDLE in cycle R+1; the next accept is possible at edge R+1.
- A held request is never starved: a requester waiting while the other completes is granted on the next IDLE.
- alu_* holds the last operation between ops; no glitching of alu_sel in RESP.

## Structure
- Package `am_ctrl_pkg` holds:
  - the state enum (IDLE, EXEC, RESP);
  - Sel opcode constants: OP_PRIO = 0, OP_AND = 1, OP_XOR = 2, OP_MUL = 3, OP_ASR = 4, OP_ASL = 5, OP_LSR = 6, OP_LSL = 7, OP_DEC2 = 8, OP_DEC4 = 9, OP_MAX = 10, OP_MIN = 11, OP_ADD = 12, OP_SUB = 13, OP_ABSSUB = 14, OP_MULG = 15.
- One sub-module, `rr_arb2`, is the natural split: a two-input round-robin grant from valids plus a last_grant input; combinational only.
- The FSM, registers and counters live in `am_ctrl`.

## Test plan
1. Only req0: a=3, b=4, sel=OP_ADD → accept at T, rsp0_valid at T+2, rsp0_out=16'h0007, ovf=0, cnt0=1.
2. Only req1: a=7, b=1, sel=OP_ADD → rsp1_out=16'h0008, rsp1_ovf=1, cnt1=1; rsp0_valid stays 0.
3. Both valid from reset: req0 a=4'hE, b=3, sel=OP_MUL; req1 a=5, b=2, sel=OP_XOR.
   - req0 is served first: rsp0_out=16'h00FA.
   - req1 is served next: rsp1_out=16'h0007.
   - The grants alternate over 6 back-to-back ops with both valids held.
4. Response backpressure: rsp0_ready held low for 10 cycles → rsp0_valid and data stable, req0_ready/req1_ready stay 0, busy=1; release → IDLE the next cycle.
5. Reset mid-operation: assert rst_n low during EXEC → all outputs 0 immediately, no response, cnt unchanged at 0; the next request completes normally.
6. Counter saturation with CNT_W=2: 5 completed req0 ops → cnt0 sticks at 2'b11.
